// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide on magnitudes, one bit per cycle.
// Latency XLEN+1 cycles (1 for divide-by-zero / signed overflow); busy stalls the core, starts while busy are dropped.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd,
  output logic            busy,
  output logic            done,
  output logic            wb_en,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   acc_q, acc_d;     // product high half / partial remainder
  logic [XLEN-1:0]   lo_q, lo_d;       // multiplier shifting out / dividend shifting into quotient
  logic [XLEN-1:0]   opb_q, opb_d;     // multiplicand / divisor magnitude
  logic [1:0]        op_q, op_d;
  logic              neg_q, neg_d;     // negate product or quotient
  logic              rneg_q, rneg_d;   // negate remainder
  logic [4:0]        rd_lat_q, rd_lat_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              a_signed, b_signed, a_sgn, b_sgn;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              div_by_zero, div_ovf;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_prod_n, prod_s;
  logic [XLEN:0]     div_shift, div_diff;
  logic              div_ok;
  logic [XLEN-1:0]   div_rem_n, div_quo_n, quo_s, rem_s;

  always_comb begin
    if (funct3[2]) begin
      a_signed = ~funct3[0];
      b_signed = ~funct3[0];
    end else begin
      a_signed = (funct3[1:0] != 2'b11);
      b_signed = ~funct3[1];
    end
    a_sgn = a_signed & rs1_data[XLEN-1];
    b_sgn = b_signed & rs2_data[XLEN-1];
    a_mag = a_sgn ? -rs1_data : rs1_data;
    b_mag = b_sgn ? -rs2_data : rs2_data;
    div_by_zero = (rs2_data == '0);
    div_ovf     = ~funct3[0] & (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) & (rs2_data == '1);

    mul_sum    = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
    mul_prod_n = {mul_sum, lo_q[XLEN-1:1]};
    prod_s     = neg_q ? -mul_prod_n : mul_prod_n;

    div_shift = {acc_q, lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opb_q};
    div_ok    = ~div_diff[XLEN];
    div_rem_n = div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
    div_quo_n = {lo_q[XLEN-2:0], div_ok};
    quo_s     = neg_q ? -div_quo_n : div_quo_n;
    rem_s     = rneg_q ? -div_rem_n : div_rem_n;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    lo_d     = lo_q;
    opb_d    = opb_q;
    op_d     = op_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    rd_lat_d = rd_lat_q;
    wb_rd_d  = wb_rd_q;
    result_d = result_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d     = funct3[1:0];
          rd_lat_d = rd;
          cnt_d    = '0;
          acc_d    = '0;
          neg_d    = a_sgn ^ b_sgn;
          rneg_d   = a_sgn;
          if (!funct3[2]) begin
            opb_d   = a_mag;
            lo_d    = b_mag;
            state_d = S_MUL;
          end else if (div_by_zero) begin
            // Fixed answers need no iterations: resolve now and report next cycle.
            result_d = funct3[1] ? rs1_data : '1;
            wb_rd_d  = rd;
            state_d  = S_DONE;
          end else if (div_ovf) begin
            result_d = funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
            wb_rd_d  = rd;
            state_d  = S_DONE;
          end else begin
            opb_d   = b_mag;
            lo_d    = a_mag;
            state_d = S_DIV;
          end
        end
      end
      S_MUL: begin
        acc_d = mul_prod_n[2*XLEN-1:XLEN];
        lo_d  = mul_prod_n[XLEN-1:0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(XLEN-1)) begin
          result_d = (op_q == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
          wb_rd_d  = rd_lat_q;
          state_d  = S_DONE;
        end
      end
      S_DIV: begin
        acc_d = div_rem_n;
        lo_d  = div_quo_n;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(XLEN-1)) begin
          result_d = op_q[1] ? rem_s : quo_s;
          wb_rd_d  = rd_lat_q;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      lo_q     <= '0;
      opb_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      rd_lat_q <= '0;
      wb_rd_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      lo_q     <= lo_d;
      opb_q    <= opb_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      rd_lat_q <= rd_lat_d;
      wb_rd_q  <= wb_rd_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign wb_en  = done & (wb_rd_q != 5'd0);
  assign wb_rd  = wb_rd_q;
  assign result = result_q;

endmodule
